// File: rtl/time_entry_counter_pkg.sv
// Shared constants for the microwave time-entry counter: state encoding and BCD limits.
package time_entry_counter_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ENTRY = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   typedef enum logic [2:0] {
      IDLE  = ST_IDLE,
      ENTRY = ST_ENTRY,
      RUN   = ST_RUN,
      PAUSE = ST_PAUSE,
      DONE  = ST_DONE
   } state_t;

   localparam logic [3:0] BCD_NINE     = 4'd9;
   localparam logic [3:0] MAX_TENS_DEF = 4'd5;

   function automatic logic bcd_valid(input logic [3:0] d);
      return (d <= BCD_NINE);
   endfunction

endpackage

// File: rtl/time_entry_counter_bcd_digit_dec.sv
// One BCD digit of the countdown chain: decrements on borrow_in and reloads on underflow.
module bcd_digit_dec #(
   parameter logic [3:0] RELOAD = 4'd9
) (
   input  logic [3:0] digit_in,
   input  logic       borrow_in,
   output logic [3:0] digit_out,
   output logic       borrow_out
);

   // Borrow-driven decrement with reload on zero.
   always_comb begin
      digit_out  = digit_in;
      borrow_out = 1'b0;
      if (borrow_in) begin
         if (digit_in == 4'd0) begin
            digit_out  = RELOAD;
            borrow_out = 1'b1;
         end else begin
            digit_out  = digit_in - 4'd1;
            borrow_out = 1'b0;
         end
      end else begin
         digit_out  = digit_in;
         borrow_out = 1'b0;
      end
   end

endmodule

// File: rtl/time_entry_counter.sv
// Microwave time-entry counter: keypad digit shift-in, start/stop/pause control,
// and a 1 Hz BCD countdown of M:SS with a completion pulse.
module time_entry_counter
   import time_entry_counter_pkg::*;
#(
   parameter logic [3:0] MAX_TENS = MAX_TENS_DEF
) (
   input  logic       clk,
   input  logic       clearn,
   input  logic [3:0] D,
   input  logic       loadn,
   input  logic       pgt_1Hz,
   input  logic       startn,
   input  logic       stopn,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic       zero,
   output logic       running,
   output logic       done
);

   state_t     state_r;
   logic       loadn_q_r;
   logic       pgt_q_r;
   logic       key_armed_r;

   logic       key_s;
   logic       tick_s;
   logic       start_s;
   logic       stop_s;
   logic [3:0] dec_ones_s;
   logic [3:0] dec_tens_s;
   logic [3:0] dec_min_s;
   logic       b_ones_s;
   logic       b_tens_s;
   logic       b_min_s;
   logic       dec_zero_s;

   // A key held through reset stays disarmed until loadn has been seen high.
   assign key_s      = ~loadn & loadn_q_r & key_armed_r & bcd_valid(D);
   // A tick that would underflow 0:00 is blocked so the digits can never wrap.
   assign tick_s     = pgt_1Hz & ~pgt_q_r & ~b_min_s;
   assign start_s    = ~startn;
   assign stop_s     = ~stopn;
   assign zero       = (sec_ones == 4'd0) && (sec_tens == 4'd0) && (min_ones == 4'd0);
   assign dec_zero_s = (dec_ones_s == 4'd0) && (dec_tens_s == 4'd0) && (dec_min_s == 4'd0);

   bcd_digit_dec #(.RELOAD(BCD_NINE)) u_dec_ones (
      .digit_in  (sec_ones),
      .borrow_in (1'b1),
      .digit_out (dec_ones_s),
      .borrow_out(b_ones_s)
   );

   bcd_digit_dec #(.RELOAD(MAX_TENS)) u_dec_tens (
      .digit_in  (sec_tens),
      .borrow_in (b_ones_s),
      .digit_out (dec_tens_s),
      .borrow_out(b_tens_s)
   );

   bcd_digit_dec #(.RELOAD(BCD_NINE)) u_dec_min (
      .digit_in  (min_ones),
      .borrow_in (b_tens_s),
      .digit_out (dec_min_s),
      .borrow_out(b_min_s)
   );

   // Control FSM with registered digits, running and done; priority stop > start > tick > digit.
   always_ff @(posedge clk) begin
      if (!clearn) begin
         state_r     <= IDLE;
         {min_ones, sec_tens, sec_ones} <= 12'h000;
         done        <= 1'b0;
         running     <= 1'b0;
         loadn_q_r   <= 1'b1;
         pgt_q_r     <= 1'b1;
         key_armed_r <= 1'b0;
      end else begin
         loadn_q_r   <= loadn;
         pgt_q_r     <= pgt_1Hz;
         key_armed_r <= key_armed_r | loadn;
         done        <= 1'b0;
         case (state_r)
            IDLE, DONE: begin
               if (stop_s) begin
                  state_r <= IDLE;
                  {min_ones, sec_tens, sec_ones} <= 12'h000;
                  running <= 1'b0;
               end else if (key_s) begin
                  state_r <= ENTRY;
                  {min_ones, sec_tens, sec_ones} <= {sec_tens, sec_ones, D};
               end
            end
            ENTRY: begin
               if (stop_s) begin
                  state_r <= IDLE;
                  {min_ones, sec_tens, sec_ones} <= 12'h000;
                  running <= 1'b0;
               end else if (start_s && !zero) begin
                  state_r <= RUN;
                  running <= 1'b1;
               end else if (key_s) begin
                  {min_ones, sec_tens, sec_ones} <= {sec_tens, sec_ones, D};
               end
            end
            RUN: begin
               if (stop_s) begin
                  state_r <= PAUSE;
                  running <= 1'b0;
               end else if (tick_s) begin
                  {min_ones, sec_tens, sec_ones} <= {dec_min_s, dec_tens_s, dec_ones_s};
                  if (dec_zero_s) begin
                     state_r <= DONE;
                     done    <= 1'b1;
                     running <= 1'b0;
                  end
               end
            end
            PAUSE: begin
               if (stop_s) begin
                  state_r <= IDLE;
                  {min_ones, sec_tens, sec_ones} <= 12'h000;
                  running <= 1'b0;
               end else if (start_s && !zero) begin
                  state_r <= RUN;
                  running <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               {min_ones, sec_tens, sec_ones} <= 12'h000;
               running <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time_entry_counter.sv
// Self-checking bench for time_entry_counter: directed scenarios plus a randomized
// phase, all checked every cycle against a digit-level behavioural model.
module tb_time_entry_counter;
   import time_entry_counter_pkg::*;

   logic       clk;
   logic       clearn;
   logic [3:0] D;
   logic       loadn;
   logic       pgt_1Hz;
   logic       startn;
   logic       stopn;
   logic [3:0] sec_ones;
   logic [3:0] sec_tens;
   logic [3:0] min_ones;
   logic       zero;
   logic       running;
   logic       done;

   int total = 0;
   int bad   = 0;

   // reference model state
   state_t m_state;
   int     m_min, m_tens, m_ones;
   logic   m_done;
   logic   m_lq, m_pq, m_armed;

   time_entry_counter dut (
      .clk     (clk),
      .clearn  (clearn),
      .D       (D),
      .loadn   (loadn),
      .pgt_1Hz (pgt_1Hz),
      .startn  (startn),
      .stopn   (stopn),
      .sec_ones(sec_ones),
      .sec_tens(sec_tens),
      .min_ones(min_ones),
      .zero    (zero),
      .running (running),
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int model_total();
      return m_min * 100 + m_tens * 10 + m_ones;
   endfunction

   // Apply the behavioural rules for one clock edge using the inputs currently driven.
   task automatic model_step();
      logic key, tick, stp, strt;
      if (!clearn) begin
         m_state = IDLE;
         m_min = 0; m_tens = 0; m_ones = 0;
         m_done = 1'b0; m_lq = 1'b1; m_pq = 1'b1; m_armed = 1'b0;
      end else begin
         key  = !loadn && m_lq && m_armed && (D <= 4'd9);
         tick = pgt_1Hz && !m_pq;
         stp  = !stopn;
         strt = !startn;
         m_done = 1'b0;
         if (m_state == RUN) begin
            if (stp) m_state = PAUSE;
            else if (tick && model_total() != 0) begin
               if (m_ones > 0) m_ones--;
               else begin
                  m_ones = 9;
                  if (m_tens > 0) m_tens--;
                  else begin m_tens = 5; m_min--; end
               end
               if (model_total() == 0) begin m_state = DONE; m_done = 1'b1; end
            end
         end else if (stp) begin
            m_state = IDLE;
            m_min = 0; m_tens = 0; m_ones = 0;
         end else if (strt && (m_state == ENTRY || m_state == PAUSE) && model_total() != 0) begin
            m_state = RUN;
         end else if (key && m_state != PAUSE) begin
            m_min = m_tens; m_tens = m_ones; m_ones = int'(D);
            m_state = ENTRY;
         end
         if (loadn) m_armed = 1'b1;
         m_lq = loadn;
         m_pq = pgt_1Hz;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      check("digits", {4'd0, min_ones, sec_tens, sec_ones},
            {4'd0, 4'(m_min), 4'(m_tens), 4'(m_ones)});
      check("running", {15'd0, running}, {15'd0, (m_state == RUN)});
      check("done",    {15'd0, done},    {15'd0, m_done});
      check("zero",    {15'd0, zero},    {15'd0, (model_total() == 0)});
      check("state",   {13'd0, dut.state_r}, {13'd0, m_state});
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic press(input logic [3:0] d);
      D = d; loadn = 1'b0;
      cycles(10);
      loadn = 1'b1;
      cycles(2);
   endtask

   task automatic pulse_start();
      startn = 1'b0; cycles(1);
      startn = 1'b1; cycles(1);
   endtask

   task automatic pulse_stop();
      stopn = 1'b0; cycles(1);
      stopn = 1'b1; cycles(1);
   endtask

   task automatic pgt_edge();
      pgt_1Hz = 1'b1; cycles(2);
      pgt_1Hz = 1'b0; cycles(2);
   endtask

   task automatic expect_time(input string tag, input logic [11:0] t, input logic [2:0] st);
      check({tag, "_time"},  {4'd0, min_ones, sec_tens, sec_ones}, {4'd0, t});
      check({tag, "_state"}, {13'd0, dut.state_r}, {13'd0, st});
   endtask

   initial begin
      clearn = 1'b0; D = 4'd0; loadn = 1'b1; pgt_1Hz = 1'b0; startn = 1'b1; stopn = 1'b1;
      #2;
      cycles(2);
      expect_time("reset", 12'h000, ST_IDLE);
      check("reset_running", {15'd0, running}, 16'd0);
      check("reset_done",    {15'd0, done},    16'd0);
      check("reset_zero",    {15'd0, zero},    16'd1);
      clearn = 1'b1;
      cycles(2);

      // keys 1,3,0 -> 1:30
      press(4'd1); press(4'd3); press(4'd0);
      expect_time("entry130", 12'h130, ST_ENTRY);

      // 1:00 start, one edge -> 0:59
      pulse_stop();
      press(4'd1); press(4'd0); press(4'd0);
      pulse_start();
      pgt_edge();
      expect_time("borrow059", 12'h059, ST_RUN);
      check("borrow059_running", {15'd0, running}, 16'd1);

      // 0:02 counts out to DONE with a single done pulse
      pulse_stop(); pulse_stop();
      press(4'd0); press(4'd0); press(4'd2);
      pulse_start();
      pgt_edge();
      expect_time("cd001", 12'h001, ST_RUN);
      pgt_1Hz = 1'b1; cycles(1);
      check("done_pulse", {15'd0, done}, 16'd1);
      check("done_zero",  {15'd0, zero}, 16'd1);
      check("done_run",   {15'd0, running}, 16'd0);
      pgt_1Hz = 1'b0; cycles(1);
      check("done_drop", {15'd0, done}, 16'd0);
      expect_time("done", 12'h000, ST_DONE);

      // pause at 0:45, resume to 0:44, stop twice
      press(4'd4); press(4'd6);
      pulse_start();
      pgt_edge();
      expect_time("run045", 12'h045, ST_RUN);
      pulse_stop();
      pgt_edge(); pgt_edge(); pgt_edge();
      expect_time("pause045", 12'h045, ST_PAUSE);
      pulse_start();
      pgt_edge();
      expect_time("resume044", 12'h044, ST_RUN);
      pulse_stop();
      expect_time("pause044", 12'h044, ST_PAUSE);
      pulse_stop();
      expect_time("cancel", 12'h000, ST_IDLE);

      // invalid digit, then digit during RUN
      press(4'hC);
      expect_time("bad_digit", 12'h000, ST_IDLE);
      press(4'd1); press(4'd2);
      pulse_start();
      press(4'd5);
      expect_time("run_key", 12'h012, ST_RUN);

      // 0:99 counts digit-wise
      pulse_stop(); pulse_stop();
      press(4'd9); press(4'd9);
      pulse_start();
      for (int i = 0; i < 10; i++) pgt_edge();
      expect_time("t99", 12'h089, ST_RUN);

      // reset mid-RUN at 0:37 with a key held
      pulse_stop(); pulse_stop();
      press(4'd3); press(4'd8);
      pulse_start();
      pgt_edge();
      expect_time("run037", 12'h037, ST_RUN);
      D = 4'd7; loadn = 1'b0;
      cycles(1);
      clearn = 1'b0; cycles(2);
      clearn = 1'b1; cycles(5);
      expect_time("held_key", 12'h000, ST_IDLE);
      loadn = 1'b1; cycles(1);
      loadn = 1'b0; cycles(2);
      expect_time("new_press", 12'h007, ST_ENTRY);
      loadn = 1'b1; cycles(2);

      // randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         clearn  = ($urandom_range(0, 299) != 0);
         if ($urandom_range(0, 3) == 0) loadn = ~loadn;
         D       = 4'($urandom_range(0, 15));
         startn  = ($urandom_range(0, 7) != 0);
         stopn   = ($urandom_range(0, 39) != 0);
         if ($urandom_range(0, 2) == 0) pgt_1Hz = ~pgt_1Hz;
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/time_entry_counter.md
TIME_ENTRY_COUNTER -- requirements
Module: time_entry_counter

Interface
REQ-001 The block SHALL have parameter MAX_TENS, default 5, the seconds-tens value loaded on a minute borrow.
REQ-002 The block SHALL have port clk, input, 1 bit, the single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port clearn, input, 1 bit, synchronous active-low reset.
REQ-004 The block SHALL have port D, input, 4 bits, the BCD digit from the keypad encoder.
REQ-005 The block SHALL have port loadn, input, 1 bit, the active-low digit-valid strobe from the encoder, held low while a key is held.
REQ-006 The block SHALL have port pgt_1Hz, input, 1 bit, the 1 Hz timebase; only its rising edges count.
REQ-007 The block SHALL have port startn, input, 1 bit, active-low start request, level-sampled.
REQ-008 The block SHALL have port stopn, input, 1 bit, active-low stop/cancel request, level-sampled.
REQ-009 The block SHALL have ports sec_ones, sec_tens and min_ones, outputs, 4 bits each, the BCD time digits.
REQ-010 The block SHALL have ports zero, running and done, outputs, 1 bit each: time==000, countdown active, and a one-cycle pulse on countdown completion.

Function
REQ-011 The block SHALL implement states IDLE, ENTRY, RUN, PAUSE and DONE, with registered outputs.
REQ-012 The block SHALL accept a digit only at a clk edge where loadn==0 and the registered loadn_q==1, so one key press loads exactly one digit however long it is held.
REQ-013 An accepted digit SHALL shift in: min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D, and the old min_ones is discarded; the result is visible after that same edge.
REQ-014 A digit with D>9 SHALL be ignored: no shift and no state change.
REQ-015 Digits SHALL be accepted in IDLE, ENTRY and DONE (which then go to ENTRY) and ignored in RUN and PAUSE.
REQ-016 startn==0 in ENTRY or PAUSE with a nonzero time SHALL move the block to RUN; with a zero time it SHALL be ignored.
REQ-017 In RUN, each detected pgt_1Hz rising edge (pgt_1Hz==1 and pgt_q==0) SHALL decrement the time by one second, with at most one decrement per edge.
REQ-018 The decrement SHALL work as follows: if sec_ones>0, sec_ones-1; else sec_ones=9 and, if sec_tens>0, sec_tens-1; else sec_tens=MAX_TENS and min_ones-1.
REQ-019 An entered sec_tens above MAX_TENS (e.g. 0:99) SHALL be legal and count down digit-wise without correction.
REQ-020 When a decrement yields 000, the block SHALL go RUN->DONE, pulse done high for exactly one cycle, and drive running=0.
REQ-021 stopn==0 in RUN SHALL move the block to PAUSE with the time held.
REQ-022 stopn==0 in PAUSE, ENTRY or DONE SHALL clear all digits to 0 and move the block to IDLE.
REQ-023 When events coincide, the priority SHALL be stopn > startn > tick > digit; if stop and tick fall in the same cycle, no decrement occurs.
REQ-024 running SHALL be 1 only in RUN, and zero SHALL be combinationally derived from the registered digits.
REQ-025 pgt_1Hz edges outside RUN SHALL be ignored, though pgt_q is still updated every cycle.

Reset
REQ-026 clearn==0 at a clk edge SHALL set state=IDLE, all digits=0, done=0, running=0, loadn_q=1 and pgt_q=1, so that no spurious edge is seen after release.
REQ-027 Reset SHALL override every other input, including mid-RUN and mid-press; a key still held across release SHALL NOT load a digit until loadn rises and falls again.

Structure
REQ-028 The state encoding (3-bit localparams IDLE..DONE) and the BCD constants (9, MAX_TENS default) SHALL live in a shared microwave package/include file.
REQ-029 One sub-module, bcd_digit_dec (BCD digit, borrow_in -> digit_out, borrow_out, with reload value as a parameter), SHALL be instantiated three times.

Verification
REQ-030 A bench SHALL press keys 1,3,0 (loadn low for 10 cycles each) and check that digits are 1:30 after exactly three shifts, with state ENTRY.
REQ-031 A bench SHALL load 1:00, pulse startn, apply one pgt_1Hz edge, and check 0:59, running=1.
REQ-032 A bench SHALL load 0:02, start, apply 2 edges, and check 000, zero=1, done high for exactly one cycle, and state DONE.
REQ-033 A bench SHALL assert stopn in RUN at 0:45 (time holds through 3 edges), release stopn, assert startn to resume (counts down to 0:44), then stop twice to reach IDLE at 000.
REQ-034 A bench SHALL drive D=4'hC with a loadn press and check no change, then press 5 during RUN and check it is ignored.
REQ-035 A bench SHALL assert clearn mid-RUN at 0:37 with loadn held low and check 000 and IDLE, with no digit loaded after release until a new loadn falling edge.
